// File: rtl/fpf_pkg.sv
// Fibonacci-code (FPF) helpers shared by the encoder and the future decoder.
//   fns(k)               : Fibonacci number, fns(1)=fns(2)=1
//   fpf_dw(n)            : input data width for an n-bit code
//   fpf_per(n,s)         : bit decisions per stage (ceiling split)
//   fpf_stage_dec(n,s,i) : decisions performed by stage i (last stage takes the shortfall)
//   fpf_stage_hi(n,s,i)  : code bit index of the first decision in stage i
package fpf_pkg;

  function automatic longint unsigned fns(input int k);
    longint unsigned a = 1;
    longint unsigned b = 1;
    longint unsigned t;
    for (int i = 3; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic int fpf_dw(input int n);
    return $clog2(fns(n + 2));
  endfunction

  function automatic int fpf_per(input int n, input int stages);
    return (n - 1 + stages - 1) / stages;
  endfunction

  function automatic int fpf_stage_dec(input int n, input int stages, input int idx);
    int rem;
    rem = n - 1 - idx * fpf_per(n, stages);
    if (rem < 0) return 0;
    if (rem > fpf_per(n, stages)) return fpf_per(n, stages);
    return rem;
  endfunction

  function automatic int fpf_stage_hi(input int n, input int stages, input int idx);
    return n - 1 - idx * fpf_per(n, stages);
  endfunction

endpackage

// File: rtl/fpf_enc_stage.sv
// One FPF encoder pipeline stage: CNT sequential bit decisions starting at
// code bit HI and walking down, followed by a stall-gated stage register.
// Ports:
//   clock, reset  : clock and synchronous active-high reset (valid bit only)
//   i_adv         : global advance; the register loads only when high
//   i_vld/i_rem/i_code/i_err : beat entering the stage
//   o_vld/o_rem/o_code/o_err : registered beat leaving the stage
module fpf_enc_stage
  import fpf_pkg::*;
#(
  parameter int N   = 28,
  parameter int DW  = 20,
  parameter int HI  = 27,
  parameter int CNT = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_adv,
  input  logic          i_vld,
  input  logic [DW-1:0] i_rem,
  input  logic [N-1:0]  i_code,
  input  logic          i_err,
  output logic          o_vld,
  output logic [DW-1:0] o_rem,
  output logic [N-1:0]  o_code,
  output logic          o_err
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic          w_prev0;
  logic          w_bit;
  logic [DW-1:0] w_rem;
  logic [N-1:0]  w_code;
  logic          r_vld_p0;
  logic [DW-1:0] r_rem_p0;
  logic [N-1:0]  r_code_p0;
  logic          r_err_p0;

  // The undecided middle case repeats the bit above; the top code bit has
  // nothing above it and behaves as if that bit were 0.
  if (CNT > 0 && HI < N - 1) begin : g_prev
    assign w_prev0 = i_code[HI+1];
  end else begin : g_top
    assign w_prev0 = 1'b0;
  end

  always_comb begin
    w_rem  = i_rem;
    w_code = i_code;
    w_bit  = w_prev0;
    for (int j = 0; j < CNT; j++) begin
      if (w_rem < DW'(fns(HI - j + 1)))
        w_bit = 1'b0;
      else if (w_rem >= DW'(fns(HI - j + 2)))
        w_bit = 1'b1;
      w_code = (w_code & ~(ONE << (HI - j))) | ({{(N-1){1'b0}}, w_bit} << (HI - j));
      if (w_bit)
        w_rem = w_rem - DW'(fns(HI - j + 1));
    end
    // Bit 0 is the remainder; later stages overwrite it until the last one.
    w_code[0] = w_rem[0];
    if (i_err)
      w_code = '0;
  end

  // ---- stage register boundary ----
  always_ff @(posedge clock) begin
    if (reset)
      r_vld_p0 <= 1'b0;
    else if (i_adv)
      r_vld_p0 <= i_vld;
  end

  always_ff @(posedge clock) begin
    if (i_adv) begin
      r_rem_p0  <= w_rem;
      r_code_p0 <= w_code;
      r_err_p0  <= i_err;
    end
  end

  assign o_vld  = r_vld_p0;
  assign o_rem  = r_rem_p0;
  assign o_code = r_code_p0;
  assign o_err  = r_err_p0;

endmodule

// File: rtl/fpf_encoder_pipe.sv
// Pipelined FPF (Fibonacci-code) encoder with a valid/ready stream on each
// side and a single global stall.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; datain is DW-bit unsigned
//   out_valid/out_ready  : output handshake
//   codeout              : N-bit codeword (zero when out_valid is low)
//   out_err              : source value was >= fns(N+2)
module fpf_encoder_pipe
  import fpf_pkg::*;
#(
  parameter  int N      = 28,
  parameter  int STAGES = 4,
  localparam int DW     = fpf_dw(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] datain,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  codeout,
  output logic          out_err
);

  if (N < 3 || N > 40 || STAGES < 1 || STAGES > N - 1) begin : g_param_check
    $error("fpf_encoder_pipe: N must be 3..40 and STAGES 1..N-1");
  end

  // One extra bit so the range limit is representable even when it is 2**DW.
  localparam logic [DW:0] LIMIT = (DW + 1)'(fns(N + 2));

  logic          w_adv;
  logic          w_vld  [0:STAGES];
  logic [DW-1:0] w_rem  [0:STAGES];
  logic [N-1:0]  w_code [0:STAGES];
  logic          w_err  [0:STAGES];
  // The last remainder has already been folded into code bit 0.
  logic [DW-1:0] w_rem_unused;

  // Everything moves together unless a valid output is being held back.
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv | reset;

  assign w_vld[0]  = in_valid;
  assign w_rem[0]  = datain;
  assign w_code[0] = '0;
  assign w_err[0]  = ({1'b0, datain} >= LIMIT);

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // ---- stage s boundary ----
    fpf_enc_stage #(
      .N   (N),
      .DW  (DW),
      .HI  (fpf_stage_hi(N, STAGES, s)),
      .CNT (fpf_stage_dec(N, STAGES, s))
    ) u_stage (
      .clock  (clock),
      .reset  (reset),
      .i_adv  (w_adv),
      .i_vld  (w_vld[s]),
      .i_rem  (w_rem[s]),
      .i_code (w_code[s]),
      .i_err  (w_err[s]),
      .o_vld  (w_vld[s+1]),
      .o_rem  (w_rem[s+1]),
      .o_code (w_code[s+1]),
      .o_err  (w_err[s+1])
    );
  end

  assign w_rem_unused = w_rem[STAGES];

  // Data registers are never reset, so outputs are qualified by the
  // (reset) valid bit to read as zero after reset.
  assign out_valid = w_vld[STAGES];
  assign codeout   = out_valid ? w_code[STAGES] : '0;
  assign out_err   = out_valid & w_err[STAGES];

endmodule

// File: doc/fpf_encoder_pipe.md
FPF_ENCODER_PIPE -- requirements
Module: fpf_encoder_pipe

Interface
REQ-001 SHALL have parameter N, default 28: FPF code width in bits, legal range 3..40.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth in cycles, legal range 1..N-1.
REQ-003 SHALL have derived constant DW = clog2(fns(N+2)), the input data width.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: datain is presented this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts datain this cycle.
REQ-008 SHALL have port datain, input, DW bits: unsigned value to encode.
REQ-009 SHALL have port out_valid, output, 1 bit: codeout and out_err are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the output.
REQ-011 SHALL have port codeout, output, N bits: FPF codeword, registered.
REQ-012 SHALL have port out_err, output, 1 bit: the source datain was out of range, registered.

Function
REQ-013 SHALL define fns(1)=1, fns(2)=1 and fns(k)=fns(k-1)+fns(k-2); valid input range is 0 <= datain < fns(N+2).
REQ-014 SHALL compute code[N-1] = (datain >= fns(N+1)), then r = datain - code[N-1]*fns(N).
REQ-015 SHALL, for each i from N-2 down to 1, set code[i] = 0 if r < fns(i+1), else 1 if r >= fns(i+2), else code[i+1]; then r = r - code[i]*fns(i+1).
REQ-016 SHALL set code[0] to the final remainder r, bit 0 of the remainder.
REQ-017 SHALL carry the remainder at DW bits, since every intermediate remainder is below fns(N+2).
REQ-018 SHALL partition the N-1 sequential bit decisions over STAGES register stages, with ceil((N-1)/STAGES) decisions per stage and any shortfall absorbed in the last stage.
REQ-019 SHALL register at each stage boundary: a valid bit, the remainder, the resolved code bits so far, and the err flag.
REQ-020 SHALL set latency to exactly STAGES cycles from an accepted beat (in_valid & in_ready) to out_valid, with no stalls.
REQ-021 SHALL sustain throughput of 1 beat/cycle while out_ready is held high.
REQ-022 SHALL use a global stall: adv = ~out_valid | out_ready; in_ready = adv; all stages shift only when adv is 1.
REQ-023 SHALL hold out_valid, codeout and out_err stable while out_valid=1 and out_ready=0.
REQ-024 SHALL allow bubbles: a beat with in_valid=0 while adv=1 inserts an invalid stage, and no output beat is produced for it.
REQ-025 SHALL set err = (datain >= fns(N+2)) at acceptance; an erroneous beat still flows with codeout forced to all-zeros and out_err=1.
REQ-026 SHALL leave the stage data registers free of reset; only valid bits are reset.
REQ-027 SHALL ensure in_valid=1 with in_ready=0 neither loses nor duplicates the beat; the source holds the beat until it is accepted.

Reset
REQ-028 SHALL, while reset=1, synchronously clear all stage valid bits and out_valid to 0 on the next rising clock edge; in_ready=1 during reset.
REQ-029 SHALL set codeout and out_err to 0 after reset.
REQ-030 SHALL discard all in-flight beats on reset mid-operation; no output beat is produced for them after reset deasserts.
REQ-031 SHALL accept a new beat in the first cycle after reset deasserts.

Structure
REQ-032 SHALL place the fns() constant function, the DW width function and the per-stage decision-count function in shared package fpf_pkg; the future decoder reuses this package.
REQ-033 SHALL implement one sub-module, fpf_enc_stage, parameterised by top-bit index and decision count: combinational decisions followed by a stall-gated stage register.
REQ-034 SHALL build the top level as a generate chain of STAGES fpf_enc_stage instances plus the handshake logic.

Verification
REQ-035 SHALL verify N=3, STAGES=1, inputs 0,1,2,3,4 back-to-back: codeout 000,001,011,110,111 on consecutive cycles, starting 1 cycle after the first accept.
REQ-036 SHALL verify N=4, STAGES=3, inputs 7 then 4: codeout 1111 then 0111, 3 cycles after each respective accept, with out_err=0.
REQ-037 SHALL verify N=3, input 5: out_err=1, codeout=000.
REQ-038 SHALL verify N=28, STAGES=4, 10k random in-range inputs with random out_ready against a reference model: every codeout matches, no 010/101 pattern appears in codeout, output order is preserved, and no beat is lost or duplicated.
REQ-039 SHALL verify out_ready=0 for 5 cycles with the pipeline full: in_ready=0, codeout stable, and the outputs then drain in order.
REQ-040 SHALL verify reset asserted for 1 cycle with 3 beats in flight: out_valid=0 the next cycle and no stale beat emerges afterwards.
